apb_uart_rx_regs: RTL
=====================

Name: apb_uart_rx_regs

Overview:
APB register slave for the UART receiver, and the next generation of the single-byte APB slave. It adds a parametrised RX FIFO, sticky write-1-to-clear error flags, data-size masking and a maskable interrupt. It sits between the APB bus and the rcv_block: it configures the bit period and data size, and buffers received bytes for software.

Parameters:
FIFO_DEPTH, 8, RX FIFO entries; power of two, 2..128.
BIT_PERIOD_RST, 14'd10, reset value of bit_period.
DATA_SIZE_RST, 4'd8, reset value of data_size.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
psel  in  1  APB select
penable  in  1  APB access phase
pwrite  in  1  1 = write
paddr  in  3  register address
pwdata  in  8  write data
prdata  out  8  read data, registered
pslverr  out  1  transfer error, registered
data_ready  in  1  receiver has a byte (level)
rx_data  in  8  received byte
framing_error  in  1  receiver framing error (level)
overrun_error  in  1  receiver overrun error (level)
data_read  out  1  one-cycle acknowledge to receiver
data_size  out  4  bits per character
bit_period  out  14  clocks per bit
irq  out  1  interrupt, registered

Behaviour:
- Reset (rst=1 at posedge):
  - prdata=0, pslverr=0, data_read=0, irq=0.
  - FIFO empty; error flags 0; IRQ_EN=0.
  - bit_period=BIT_PERIOD_RST, data_size=DATA_SIZE_RST.
  - A reset mid-transfer aborts that transfer; no pop, no write.
- APB phases:
  - Setup = psel & !penable. Access = psel & penable.
  - No wait states.
  - prdata/pslverr are loaded at the posedge ending setup and hold through access; they return to 0 the cycle after access.
  - Writes and pops take effect at the posedge ending access, exactly once per transfer.
- Register map (R = read, W = write):
  - 0 STATUS R: [0] fifo not empty, [1] fifo full, others 0.
  - 1 ERROR R/W1C: [0] framing sticky, [1] overrun sticky, [2] fifo overflow sticky.
  - 2 BP_LO RW: bit_period[7:0].
  - 3 BP_HI RW: bit_period[13:8] in [5:0]; [7:6] read 0.
  - 4 DSIZE RW: [3:0]. Only 5..8 are legal; an illegal value gives pslverr=1 and leaves data_size unchanged.
  - 5 IRQ_EN RW: [2:0].
  - 6 RXDATA R: FIFO head; the read pops.
  - 7 COUNT R: FIFO occupancy, 0..FIFO_DEPTH.
- Errors: a write to 0, 6 or 7 gives pslverr=1 and no side effect. Reads never error.
- RXDATA read while empty (sampled at setup): prdata=0, no pop, pslverr=0.
- Push:
  - On every data_ready cycle, data_read pulses high for that one cycle.
  - If not full, or a pop happens in the same cycle: push rx_data with bits at position ≥ data_size forced to 0.
  - If full and no pop: drop the byte and set overflow sticky.
- Simultaneous push and pop: both happen, count unchanged, including at full. Write and read pointers wrap modulo FIFO_DEPTH.
- Error flags:
  - Framing and overrun stickies are set while their inputs are high.
  - W1C clears a bit; a set in the same cycle wins over the clear.
- irq is registered: irq <= (EN[0]&not_empty) | (EN[1]&|ERROR) | (EN[2]&full).

Decomposition:
- Package apb_uart_pkg: register address localparams (ADDR_STATUS..ADDR_COUNT), ERROR/STATUS bit indices, DSIZE_MIN=5, DSIZE_MAX=8.
- Sub-module rx_fifo, parametrised by DEPTH and WIDTH=8.
  - Inputs: push, pop, wdata.
  - Outputs: rdata, full, empty, count.
  - Same clock and synchronous reset.

Test Plan:
- Reset, then read addresses 2, 3, 4 → prdata 0x0A, 0x00, 0x08; pslverr=0.
- Write DSIZE=0x09 → pslverr=1, data_size stays 8. Write 0x05, then receive rx_data=0xFF → RXDATA reads 0x1F.
- Push 8 bytes 0x01..0x08 (FIFO_DEPTH=8) → STATUS=0x03, COUNT=8. A 9th byte 0xAA → dropped, ERROR[2]=1. Read RXDATA 8× → 0x01..0x08 in order, then COUNT=0.
- FIFO full with a pop and push in the same cycle (push 0x55) → COUNT stays 8; the last read returns 0x55.
- Pulse framing_error; write ERROR=0x01 in the same cycle as another framing_error pulse → bit stays 1. A later write 0x01 → ERROR=0.
- Set IRQ_EN=0x01, push 0x33 → irq=1 one cycle after COUNT becomes 1. Read RXDATA → irq=0. Write to address 7 → pslverr=1.

Source files
------------

// File: rtl/apb_uart_rx_regs_pkg.sv
// Shared constants for the UART receive register block: register map,
// status/error bit positions and data-size limits.
package apb_uart_pkg;

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_ERROR  = 3'd1;
  localparam logic [2:0] ADDR_BP_LO  = 3'd2;
  localparam logic [2:0] ADDR_BP_HI  = 3'd3;
  localparam logic [2:0] ADDR_DSIZE  = 3'd4;
  localparam logic [2:0] ADDR_IRQ_EN = 3'd5;
  localparam logic [2:0] ADDR_RXDATA = 3'd6;
  localparam logic [2:0] ADDR_COUNT  = 3'd7;

  localparam int STATUS_NOT_EMPTY = 0;
  localparam int STATUS_FULL      = 1;

  localparam int ERR_FRAMING  = 0;
  localparam int ERR_OVERRUN  = 1;
  localparam int ERR_OVERFLOW = 2;

  localparam logic [3:0] DSIZE_MIN = 4'd5;
  localparam logic [3:0] DSIZE_MAX = 4'd8;

  function automatic logic dsize_legal(input logic [3:0] size);
    return (size >= DSIZE_MIN) && (size <= DSIZE_MAX);
  endfunction

  // Keeps the low `size` bits of a received character; size is always 5..8.
  function automatic logic [7:0] size_mask(input logic [3:0] size);
    return 8'hFF >> (4'd8 - size);
  endfunction

endpackage

// File: rtl/apb_uart_rx_regs_if.sv
// APB bus bundle between a master and the UART receive register slave.
interface apb_uart_rx_regs_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [2:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pslverr
  );
endinterface

// File: rtl/apb_uart_rx_regs_rx_fifo.sv
// Receive FIFO: array storage with wrapping pointers and an occupancy count.
// A pop frees a slot in the same cycle, so push+pop at full is accepted.
module rx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/apb_uart_rx_regs.sv
// APB register slave for the UART receiver: configuration registers,
// RX FIFO, sticky W1C error flags and a maskable registered interrupt.
module apb_uart_rx_regs
  import apb_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter logic [13:0] BIT_PERIOD_RST = 14'd10,
  parameter logic [3:0]  DATA_SIZE_RST  = 4'd8
) (
  input  logic                     clk,
  input  logic                     rst,
  apb_uart_rx_regs_if.slave        apb,
  input  logic                     data_ready,
  input  logic [7:0]               rx_data,
  input  logic                     framing_error,
  input  logic                     overrun_error,
  output logic                     data_read,
  output logic [3:0]               data_size,
  output logic [13:0]              bit_period,
  output logic                     irq
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    prdata_q, prdata_d;
  logic          pslverr_q, pslverr_d;
  logic          pop_armed_q, pop_armed_d;
  logic [2:0]    err_q, err_d, err_set, err_clr;
  logic [13:0]   bp_q, bp_d;
  logic [3:0]    ds_q, ds_d;
  logic [2:0]    en_q, en_d;
  logic          irq_q, irq_d;

  logic          setup, access, wr_err, wr_en;
  logic [7:0]    rd_val;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata, fifo_wdata;
  logic [CW-1:0] fifo_count;

  assign setup  = apb.psel & ~apb.penable;
  assign access = apb.psel & apb.penable;

  always_comb begin
    wr_err = 1'b0;
    case (apb.paddr)
      ADDR_STATUS, ADDR_RXDATA, ADDR_COUNT: wr_err = 1'b1;
      ADDR_DSIZE: wr_err = ~dsize_legal(apb.pwdata[3:0]);
      default: ;
    endcase
  end

  assign wr_en = access & apb.pwrite & ~wr_err;

  always_comb begin
    rd_val = '0;
    case (apb.paddr)
      ADDR_STATUS: begin
        rd_val[STATUS_NOT_EMPTY] = ~fifo_empty;
        rd_val[STATUS_FULL]      = fifo_full;
      end
      ADDR_ERROR:  rd_val = {5'd0, err_q};
      ADDR_BP_LO:  rd_val = bp_q[7:0];
      ADDR_BP_HI:  rd_val = {2'd0, bp_q[13:8]};
      ADDR_DSIZE:  rd_val = {4'd0, ds_q};
      ADDR_IRQ_EN: rd_val = {5'd0, en_q};
      ADDR_RXDATA: rd_val = fifo_empty ? 8'd0 : fifo_rdata;
      ADDR_COUNT:  rd_val = 8'(fifo_count);
      default:     rd_val = '0;
    endcase
  end

  // Response is captured at the end of setup; the pop decision is frozen
  // there too so the popped byte is exactly the one returned.
  assign prdata_d    = (setup & ~apb.pwrite) ? rd_val : 8'd0;
  assign pslverr_d   = setup & apb.pwrite & wr_err;
  assign pop_armed_d = setup & ~apb.pwrite & (apb.paddr == ADDR_RXDATA) & ~fifo_empty;
  assign fifo_pop    = access & pop_armed_q;

  always_comb begin
    bp_d    = bp_q;
    ds_d    = ds_q;
    en_d    = en_q;
    err_clr = '0;
    if (wr_en) begin
      case (apb.paddr)
        ADDR_ERROR:  err_clr     = apb.pwdata[2:0];
        ADDR_BP_LO:  bp_d[7:0]   = apb.pwdata;
        ADDR_BP_HI:  bp_d[13:8]  = apb.pwdata[5:0];
        ADDR_DSIZE:  ds_d        = apb.pwdata[3:0];
        ADDR_IRQ_EN: en_d        = apb.pwdata[2:0];
        default: ;
      endcase
    end
  end

  assign err_set[ERR_FRAMING]  = framing_error;
  assign err_set[ERR_OVERRUN]  = overrun_error;
  assign err_set[ERR_OVERFLOW] = data_ready & fifo_full & ~fifo_pop;

  // A set arriving in the same cycle as its W1C clear wins.
  for (genvar gi = 0; gi < 3; gi++) begin : g_err
    assign err_d[gi] = err_set[gi] | (err_q[gi] & ~err_clr[gi]);
  end

  assign irq_d = (en_q[0] & ~fifo_empty) | (en_q[1] & (|err_q)) | (en_q[2] & fifo_full);

  assign fifo_wdata = rx_data & size_mask(ds_q);

  rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (data_ready),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      prdata_q    <= '0;
      pslverr_q   <= 1'b0;
      pop_armed_q <= 1'b0;
      err_q       <= '0;
      bp_q        <= BIT_PERIOD_RST;
      ds_q        <= DATA_SIZE_RST;
      en_q        <= '0;
      irq_q       <= 1'b0;
    end else begin
      prdata_q    <= prdata_d;
      pslverr_q   <= pslverr_d;
      pop_armed_q <= pop_armed_d;
      err_q       <= err_d;
      bp_q        <= bp_d;
      ds_q        <= ds_d;
      en_q        <= en_d;
      irq_q       <= irq_d;
    end
  end

  assign apb.prdata  = prdata_q;
  assign apb.pslverr = pslverr_q;
  assign data_read   = data_ready & ~rst;
  assign data_size   = ds_q;
  assign bit_period  = bp_q;
  assign irq         = irq_q;

endmodule
